// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with HI/LO result registers.
// Multiplies by shift-add and divides by restoring division, both on operand
// magnitudes with one iteration per clock. The sign fix-up is applied when
// HI/LO are written.
// Build option: define MDU_DIV_EN to include the divide datapath. Without it,
// div/divu complete in one busy cycle, pulse done with dz=0 and leave HI/LO
// unchanged.
module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    r_prod;    // {upper acc / remainder, multiplier / quotient}
  logic [WIDTH-1:0] r_opnd;    // multiplicand or divisor magnitude
  logic             r_is_div;
  logic             r_neg_q;   // product or quotient needs negating
  logic             r_busy;
  logic             r_done;
  logic             r_dz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
`ifdef MDU_DIV_EN
  logic             r_neg_r;   // remainder takes the dividend sign
  logic             r_zero;    // divisor was zero
  logic [WIDTH-1:0] r_a;       // original dividend for the divide-by-zero result
`endif

  // Two's-complement negate at operand width
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_add;
  logic [PW-1:0]    w_mul_next;
  logic [PW-1:0]    w_next;
  logic [PW-1:0]    w_mul_res;

  // Operand magnitudes from the live inputs, captured on an accepted start
  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & a[WIDTH-1];
  assign w_b_neg  = w_signed & b[WIDTH-1];
  assign w_mag_a  = w_a_neg ? neg_w(a) : a;
  assign w_mag_b  = w_b_neg ? neg_w(b) : b;

  // One shift-add step: conditionally add, then shift {carry, acc, mplier} right
  assign w_add      = {1'b0, r_prod[PW-1:WIDTH]} + (r_prod[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_add, r_prod[WIDTH-1:1]};
  assign w_mul_res  = r_neg_q ? (~r_prod + PW'(1)) : r_prod;

`ifdef MDU_DIV_EN
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [PW-1:0]    w_div_next;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The difference is below the divisor, so WIDTH bits hold it exactly.
  assign w_shift    = {r_prod[PW-1:WIDTH], r_prod[WIDTH-1]};
  assign w_ge       = (w_shift >= {1'b0, r_opnd});
  assign w_diff     = w_shift[WIDTH-1:0] - r_opnd;
  assign w_div_next = w_ge ? {w_diff, r_prod[WIDTH-2:0], 1'b1}
                           : {w_shift[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b0};
  assign w_quo      = r_neg_q ? neg_w(r_prod[WIDTH-1:0]) : r_prod[WIDTH-1:0];
  assign w_rem      = r_neg_r ? neg_w(r_prod[PW-1:WIDTH]) : r_prod[PW-1:WIDTH];
  assign w_next     = r_is_div ? w_div_next : w_mul_next;
`else
  assign w_next     = w_mul_next;
`endif

  // Control FSM, iteration datapath and HI/LO registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
`ifdef MDU_DIV_EN
      r_neg_r  <= 1'b0;
      r_zero   <= 1'b0;
      r_a      <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_is_div <= op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_opnd   <= op[1] ? w_mag_b : w_mag_a;
            r_prod   <= {WIDTH'(0), (op[1] ? w_mag_a : w_mag_b)};
            r_cnt    <= '0;
            r_busy   <= 1'b1;
`ifdef MDU_DIV_EN
            r_neg_r  <= w_a_neg;
            r_zero   <= (b == '0);
            r_a      <= a;
            r_state  <= S_CALC;
`else
            r_state  <= op[1] ? S_FIN : S_CALC;
`endif
          end else begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
          end
        end
        S_CALC: begin
          r_prod <= w_next;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) r_state <= S_FIN;
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
          if (!r_is_div) begin
            r_hi <= w_mul_res[PW-1:WIDTH];
            r_lo <= w_mul_res[WIDTH-1:0];
          end
`ifdef MDU_DIV_EN
          else if (r_zero) begin
            r_dz <= 1'b1;
            r_lo <= '1;
            r_hi <= r_a;
          end else begin
            r_lo <= w_quo;
            r_hi <= w_rem;
          end
`endif
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign dz   = r_dz;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: scoreboard bench for mdu_iter (WIDTH=32). Each issued operation
// pushes its expected HI/LO/dz and done cycle; a monitor pops on every done.
module tb_mdu_iter;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'd0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          hi_we = 1'b0;
  logic          lo_we = 1'b0;
  logic [W-1:0]  wdata = '0;
  logic          busy;
  logic          done;
  logic          dz;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  mdu_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int unsigned cyc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural meaning of each op
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        r;
    logic [63:0] p;
    longint      sx, sy, q, rm;
    logic [63:0] uq, ur;
    r.dz = 1'b0;
    r.hi = m_hi;
    r.lo = m_lo;
    r.cyc = 0;
    r.name = "";
    sx = longint'(int'(x));
    sy = longint'(int'(y));
    case (o)
      2'd0: begin p = 64'(sx * sy); r.hi = p[63:32]; r.lo = p[31:0]; end
      2'd1: begin p = {32'd0, x} * {32'd0, y}; r.hi = p[63:32]; r.lo = p[31:0]; end
      default: begin
`ifdef MDU_DIV_EN
        if (y == 32'd0) begin
          r.dz = 1'b1; r.lo = 32'hFFFF_FFFF; r.hi = x;
        end else if (o == 2'd2) begin
          q = sx / sy; rm = sx % sy;
          r.lo = q[31:0]; r.hi = rm[31:0];
        end else begin
          uq = {32'd0, x} / {32'd0, y}; ur = {32'd0, x} % {32'd0, y};
          r.lo = uq[31:0]; r.hi = ur[31:0];
        end
`endif
      end
    endcase
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d want no pulse", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_hi"}, 64'(hi), 64'(e.hi));
        chk({e.name, "_lo"}, 64'(lo), 64'(e.lo));
        chk({e.name, "_dz"}, 64'(dz), 64'(e.dz));
        chk({e.name, "_lat"}, 64'(cyc), 64'(e.cyc));
      end
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // mode 0: plain; 1: start+writes injected on busy cycle 5; 2: writes with start
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int mode);
    exp_t e;
    int   nb;
    bit   short_op;
`ifdef MDU_DIV_EN
    short_op = 1'b0;
`else
    short_op = o[1];
`endif
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    if (mode == 2) begin hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom; end
    e = model(o, x, y);
    e.name = $sformatf("op%0d_%h_%h", o, x, y);
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    e.cyc = cyc + (short_op ? 1 : W + 1);
    sb.push_back(e);
    m_hi = e.hi;
    m_lo = e.lo;
    nb = 0;
    while (busy && nb < 200) begin
      nb++;
      if (mode == 1 && nb == 5) begin
        op = 2'd1; a = $urandom; b = $urandom; start = 1'b1;
        hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom;
      end
      @(posedge clk); #1;
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    end
    chk({e.name, "_busy_cycles"}, 64'(nb), 64'(short_op ? 1 : W + 1));
  endtask

  task automatic wr(input logic hw, input logic lw, input logic [31:0] d);
    @(negedge clk);
    hi_we = hw; lo_we = lw; wdata = d;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    if (hw) m_hi = d;
    if (lw) m_lo = d;
    chk("wr_hi", 64'(hi), 64'(m_hi));
    chk("wr_lo", 64'(lo), 64'(m_lo));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz",   64'(dz),   64'd0);
    chk("rst_hi",   64'(hi),   64'd0);
    chk("rst_lo",   64'(lo),   64'd0);
    rst = 1'b1;

    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1);
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(2'd3, 32'd100, 32'd0, 0);
    do_op(2'd0, 32'd5, 32'hFFFF_FFFA, 0);
    do_op(2'd3, 32'd9, 32'd3, 0);
    do_op(2'd2, 32'h8000_0000, 32'd0, 0);

    wr(1'b1, 1'b0, 32'h0000_1234);
    wr(1'b0, 1'b1, 32'hCAFE_0001);
    wr(1'b1, 1'b1, 32'h5A5A_A5A5);
    do_op(2'd3, 32'd17, 32'd5, 2);
    do_op(2'd1, 32'd3, 32'd4, 2);

    // Reset in the middle of CALC: no update, no done, registers cleared
    wr(1'b1, 1'b1, 32'h0BAD_F00D);
    @(negedge clk);
    op = 2'd0; a = 32'd123; b = 32'd456; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hi",   64'(hi),   64'd0);
    chk("abort_lo",   64'(lo),   64'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (50) @(negedge clk);
    chk("post_abort_hi", 64'(hi), 64'd0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 4) == 0)
        wr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      else
        do_op(2'($urandom_range(0, 3)), pick(), pick(), ($urandom_range(0, 5) == 0) ? 1 : 0);
    end

    repeat (5) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width; legal range 4..64, even values only.
REQ-002 The block SHALL have port clk, in, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, in, 1, the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have port start, in, 1, a request to begin an operation, sampled only while busy=0.
REQ-005 The block SHALL have port op, in, 2, the operation select: 00 mult (signed), 01 multu, 10 div (signed), 11 divu.
REQ-006 The block SHALL have ports a and b, in, WIDTH each: a is the multiplicand/dividend, b is the multiplier/divisor.
REQ-007 The block SHALL have ports hi_we and lo_we, in, 1 each, the direct-write strobes for HI and LO (mthi/mtlo).
REQ-008 The block SHALL have port wdata, in, WIDTH, the data for hi_we and lo_we.
REQ-009 The block SHALL have port busy, out, 1, high while an operation is in progress.
REQ-010 The block SHALL have port done, out, 1, a one-cycle pulse marking HI/LO update.
REQ-011 The block SHALL have port dz, out, 1, the divide-by-zero flag, valid only while done=1.
REQ-012 The block SHALL have ports hi and lo, out, WIDTH each, giving the registered HI and LO.

Function
REQ-013 The FSM SHALL have three states: IDLE, CALC and FIN. busy SHALL be 1 exactly while the FSM is in CALC or FIN.
REQ-014 In IDLE, if start=1 at edge k, the block SHALL latch op, a and b, then enter CALC.
REQ-015 CALC SHALL perform exactly WIDTH iterations, one per edge (k+1 through k+WIDTH), then enter FIN.
  - Multiply: shift-add on magnitudes.
  - Divide: restoring, on magnitudes.
REQ-016 At edge k+WIDTH+1, FIN SHALL do all of the following, then return to IDLE:
  - apply sign correction;
  - write HI and LO;
  - drive done=1 for that single cycle.
REQ-017 Latency SHALL be fixed: done is high in the cycle after edge k+WIDTH+1, independent of the operand values.
REQ-018 Multiply results SHALL be: HI = upper WIDTH bits and LO = lower WIDTH bits of the exact 2*WIDTH-bit product.
REQ-019 Divide results SHALL be:
  - LO = quotient, truncated toward zero;
  - HI = remainder, with the sign of the dividend.
REQ-020 Divide by zero (b=0) SHALL produce: LO = all ones, HI = a, dz=1 with done. Latency is unchanged.
REQ-021 Signed overflow (a = most negative value, b = -1) SHALL produce LO = a and HI = 0.
REQ-022 start while busy=1 SHALL be ignored; no queuing.
REQ-023 hi_we and lo_we while busy=1 SHALL be ignored.
REQ-024 In IDLE, hi_we and lo_we SHALL write wdata at the next edge; both may be active together.
REQ-025 If start and hi_we/lo_we are active in the same IDLE cycle, start SHALL win and the writes SHALL be dropped.
REQ-026 hi and lo SHALL hold their values until the next FIN or an accepted direct write.

Reset
REQ-027 When rst=0, the block SHALL immediately:
  - force the FSM to IDLE;
  - clear busy, done, dz, hi, lo and the iteration counter to 0.
REQ-028 Assertion of rst mid-operation SHALL abort the operation with no HI/LO update and no done pulse.

Configuration
REQ-029 Macro MDU_DIV_EN SHALL compile the divide datapath in or out; all other behaviour is identical in both builds.
  - Defined: div/divu SHALL behave per REQ-019 to REQ-021.
  - Undefined: no divider logic SHALL exist. op=1x SHALL pass IDLE->FIN (busy for one cycle), pulse done with dz=0, and leave hi and lo unchanged.

Verification (WIDTH=32, MDU_DIV_EN defined unless stated)
REQ-030 multu 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 edges after the start edge; busy high for 33 cycles.
REQ-031 mult -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. A second start with different operands at busy=1, cycle 5 -> ignored, result unchanged.
REQ-032 div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
REQ-033 divu 100/0 -> lo=0xFFFFFFFF, hi=0x00000064, dz=1 during done. The following mult has dz=0.
REQ-034 Two cases cover direct writes and reset:
  - hi_we with wdata=0x1234 in IDLE -> hi=0x1234. The same write during busy -> hi unchanged.
  - rst=0 at CALC iteration 10 -> hi=lo=0, busy=0, and no done pulse.
REQ-035 With MDU_DIV_EN undefined: divu 9/3 -> busy for one cycle, done pulse, hi/lo unchanged, dz=0.
